// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch stage: single-outstanding imem reads into a decode FIFO
//
// Issues one instruction-memory read at a time from the current PC and queues
// the returned {pc, instruction} pairs for decode. It also drives the PC
// register enable and flushes on redirect. A response that is still in flight
// when a redirect arrives is discarded.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   fetch_pc, redirect, hlt PC register value, control-flow change, halt
//   pc_enable               PC register advance/load enable
//   mem_req/addr/gnt        read request handshake
//   mem_rvalid/rdata        read response
//   dec_valid/pc/instr      FIFO head presented to decode
//   dec_ready               decode consumes head
//   busy                    request outstanding or FIFO non-empty
module fetch_buffer #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            redirect,
  input  logic            hlt,
  output logic            pc_enable,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [ILEN-1:0] mem_rdata,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [ILEN-1:0] dec_instr,
  input  logic            dec_ready,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] req_pc;

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [ILEN-1:0] instr_q [DEPTH];

  logic grant;
  logic push;
  logic pop;

  // Only entries are counted: with one request outstanding, a free slot seen
  // at issue time is still free when the response lands. Reset also blocks
  // issue so the PC cannot advance while the buffer is being cleared.
  assign mem_req   = ~reset & (state == IDLE) & ~hlt & ~redirect & (count < CW'(DEPTH));
  assign mem_addr  = fetch_pc;
  assign grant     = mem_req & mem_gnt;
  assign pc_enable = redirect | grant;

  // A response arriving together with a redirect belongs to the old stream.
  assign push      = (state == WAIT) & mem_rvalid & ~redirect;
  assign pop       = dec_valid & dec_ready;

  assign dec_valid = (count != '0);
  assign dec_pc    = pc_q[rd_ptr];
  assign dec_instr = instr_q[rd_ptr];
  assign busy      = (state != IDLE) | (count != '0);

  // Payload storage needs no reset; dec_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= req_pc;
      instr_q[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_pc <= '0;
    end else begin
      if (grant) begin
        req_pc <= fetch_pc;
      end

      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      case (state)
        IDLE: begin
          if (grant) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // With rvalid the response is either pushed or, on redirect,
          // dropped. Without it a redirect leaves stale data in flight.
          if (mem_rvalid) begin
            state <= IDLE;
          end else if (redirect) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            redirect = 1'b0;
  logic            hlt = 1'b0;
  logic            pc_enable;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [ILEN-1:0] mem_rdata = '0;
  logic            dec_valid;
  logic [XLEN-1:0] dec_pc;
  logic [ILEN-1:0] dec_instr;
  logic            dec_ready = 1'b0;
  logic            busy;

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_pc   (fetch_pc),
    .redirect   (redirect),
    .hlt        (hlt),
    .pc_enable  (pc_enable),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dec_valid  (dec_valid),
    .dec_pc     (dec_pc),
    .dec_instr  (dec_instr),
    .dec_ready  (dec_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  typedef struct {
    int              due;
    logic [ILEN-1:0] data;
  } resp_t;

  // Bench-side environment knobs
  int              lat = 1;
  logic            bad_mode = 1'b0;
  logic [XLEN-1:0] pc_init = 64'h2000;
  logic [XLEN-1:0] redirect_target = '0;
  logic            armed = 1'b0;

  // Values sampled at negedge, used by the PC register and memory at posedge
  logic            gnt_nb = 1'b0;
  logic [XLEN-1:0] addr_nb = '0;
  int              lat_nb = 1;
  logic            bad_nb = 1'b0;
  logic            pce_nb = 1'b0;
  logic            red_nb = 1'b0;
  logic [XLEN-1:0] tgt_nb = '0;
  logic            rst_nb = 1'b1;

  entry_t          pop_log[$];
  logic [XLEN-1:0] grant_log[$];

  // Model state: outstanding request, stale request, queued entries
  entry_t          mq[$];
  logic            m_out = 1'b0;
  logic            m_stale = 1'b0;
  logic [XLEN-1:0] m_req_pc = '0;

  function automatic logic [ILEN-1:0] rdata_of(input logic [XLEN-1:0] a);
    if (a == 64'h2000) return 32'hA1;
    return 32'h1300_0000 | {8'h00, a[23:0]};
  endfunction

  function automatic logic [63:0] gl(input int i);
    if (grant_log.size() > i) return grant_log[i];
    return '1;
  endfunction

  function automatic logic [63:0] pl_pc(input int i);
    if (pop_log.size() > i) return pop_log[i].pc;
    return '1;
  endfunction

  function automatic logic [63:0] pl_instr(input int i);
    if (pop_log.size() > i) return {32'h0, pop_log[i].instr};
    return '1;
  endfunction

  // PC register and instruction memory
  int cyc = 0;
  resp_t resp_q[$];
  always @(posedge clk) begin
    cyc++;
    if (gnt_nb === 1'b1)
      resp_q.push_back('{due: cyc + lat_nb - 1, data: (bad_nb ? 32'hBAD : rdata_of(addr_nb))});
    #1;
    mem_rvalid = 1'b0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = resp_q[0].data;
      void'(resp_q.pop_front());
    end
    if (rst_nb)
      fetch_pc = pc_init;
    else if (pce_nb === 1'b1)
      fetch_pc = red_nb ? tgt_nb : fetch_pc + 64'd4;
  end

  // Compare process plus model transition
  always @(negedge clk) begin
    logic   e_req;
    logic   e_pce;
    logic   e_val;
    logic   e_busy;
    logic   g;
    gnt_nb  = mem_req & mem_gnt;
    addr_nb = mem_addr;
    lat_nb  = lat;
    bad_nb  = bad_mode;
    pce_nb  = pc_enable;
    red_nb  = redirect;
    tgt_nb  = redirect_target;
    rst_nb  = reset;
    if (armed) begin
      e_req  = !reset && !m_out && !m_stale && !hlt && !redirect && (mq.size() < DEPTH);
      e_pce  = redirect || (e_req && mem_gnt);
      e_val  = (mq.size() != 0);
      e_busy = m_out || m_stale || (mq.size() != 0);
      check("mem_req", {63'h0, mem_req}, {63'h0, e_req});
      check("pc_enable", {63'h0, pc_enable}, {63'h0, e_pce});
      check("dec_valid", {63'h0, dec_valid}, {63'h0, e_val});
      check("busy", {63'h0, busy}, {63'h0, e_busy});
      if (e_req) check("mem_addr", mem_addr, fetch_pc);
      if (e_val) begin
        check("dec_pc", dec_pc, mq[0].pc);
        check("dec_instr", {32'h0, dec_instr}, {32'h0, mq[0].instr});
      end

      if (reset) begin
        pop_log.delete();
        grant_log.delete();
      end else begin
        if (dec_valid && dec_ready) pop_log.push_back('{pc: dec_pc, instr: dec_instr});
        if (mem_req && mem_gnt) grant_log.push_back(mem_addr);
      end

      if (reset) begin
        mq.delete();
        m_out   = 1'b0;
        m_stale = 1'b0;
      end else begin
        g = e_req && mem_gnt;
        if (redirect) begin
          mq.delete();
          if (m_out) begin
            m_stale = !mem_rvalid;
            m_out   = 1'b0;
          end else if (m_stale && mem_rvalid) begin
            m_stale = 1'b0;
          end
        end else begin
          if (mq.size() > 0 && dec_ready) void'(mq.pop_front());
          if (m_out && mem_rvalid) begin
            mq.push_back('{pc: m_req_pc, instr: mem_rdata});
            m_out = 1'b0;
          end else if (m_stale && mem_rvalid) begin
            m_stale = 1'b0;
          end
          if (g) begin
            m_out    = 1'b1;
            m_req_pc = fetch_pc;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [XLEN-1:0] pc);
    reset    = 1'b1;
    redirect = 1'b0;
    hlt      = 1'b0;
    pc_init  = pc;
    step(1);
    armed = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    int bad_seen;

    // Basic fetch with 1-cycle memory
    mem_gnt = 1'b1; dec_ready = 1'b1; lat = 1; bad_mode = 1'b0;
    reset = 1'b1;
    step(1);
    armed = 1'b1;
    @(negedge clk);
    check("reset_mem_req", {63'h0, mem_req}, 64'h0);
    check("reset_dec_valid", {63'h0, dec_valid}, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_pc_enable", {63'h0, pc_enable}, 64'h0);
    step(1);
    reset = 1'b0;
    step(6);
    check("t1_pop0_pc", pl_pc(0), 64'h2000);
    check("t1_pop0_instr", pl_instr(0), 64'hA1);
    check("t1_grant1", gl(1), 64'h2004);

    // Fill to full, then drain
    dec_ready = 1'b0;
    do_reset(64'h2000);
    step(10);
    @(negedge clk);
    check("t2_full_mem_req", {63'h0, mem_req}, 64'h0);
    check("t2_full_head_pc", dec_pc, 64'h2000);
    step(1);
    dec_ready = 1'b1;
    step(12);
    check("t2_pop0", pl_pc(0), 64'h2000);
    check("t2_pop1", pl_pc(1), 64'h2004);
    check("t2_pop1_instr", pl_instr(1), 64'h1300_2004);
    check("t2_pop2", pl_pc(2), 64'h2008);
    check("t2_pop3", pl_pc(3), 64'h200C);
    check("t2_resume", gl(4), 64'h2010);

    // Redirect while WAIT, stale 0xBAD arrives in DROP
    dec_ready = 1'b0;
    do_reset(64'h2000);
    step(4);
    lat = 2; bad_mode = 1'b1;
    step(1);
    bad_mode = 1'b0; lat = 1;
    redirect = 1'b1; redirect_target = 64'h3000;
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    check("t3_flushed", {63'h0, dec_valid}, 64'h0);
    check("t3_drop_no_req", {63'h0, mem_req}, 64'h0);
    step(1);
    dec_ready = 1'b1;
    step(6);
    check("t3_grant_target", gl(3), 64'h3000);
    check("t3_pop0_pc", pl_pc(0), 64'h3000);
    bad_seen = 0;
    foreach (pop_log[i]) if (pop_log[i].instr == 32'hBAD) bad_seen++;
    check("t3_no_bad", 64'(bad_seen), 64'h0);

    // Redirect together with rvalid in WAIT
    do_reset(64'h2000);
    step(1);
    redirect = 1'b1; redirect_target = 64'h4000;
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    check("t4_req", {63'h0, mem_req}, 64'h1);
    check("t4_addr", mem_addr, 64'h4000);
    step(5);
    check("t4_pop0_pc", pl_pc(0), 64'h4000);
    check("t4_pop0_instr", pl_instr(0), 64'h1300_4000);

    // Halt during WAIT
    lat = 3;
    do_reset(64'h2000);
    step(1);
    hlt = 1'b1;
    step(5);
    @(negedge clk);
    check("t5_busy", {63'h0, busy}, 64'h0);
    check("t5_mem_req", {63'h0, mem_req}, 64'h0);
    check("t5_pc_enable", {63'h0, pc_enable}, 64'h0);
    check("t5_pop0_pc", pl_pc(0), 64'h2000);
    check("t5_pop0_instr", pl_instr(0), 64'hA1);
    step(1);
    hlt = 1'b0; lat = 1;
    step(4);
    check("t5_resume", gl(1), 64'h2004);

    // Reset mid-WAIT with 3 entries, late rvalid ignored
    dec_ready = 1'b0; lat = 1;
    do_reset(64'h2000);
    step(6);
    lat = 3;
    step(1);
    reset = 1'b1; pc_init = 64'h5000;
    step(1);
    reset = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    check("t6_dec_valid", {63'h0, dec_valid}, 64'h0);
    check("t6_busy", {63'h0, busy}, 64'h0);
    check("t6_mem_req", {63'h0, mem_req}, 64'h1);
    step(1);
    @(negedge clk);
    check("t6_late_rvalid_seen", {63'h0, mem_rvalid}, 64'h1);
    check("t6_late_busy", {63'h0, busy}, 64'h0);
    step(1);
    mem_gnt = 1'b1; lat = 1; dec_ready = 1'b1;
    step(6);
    check("t6_pop0_pc", pl_pc(0), 64'h5000);
    check("t6_pop0_instr", pl_instr(0), 64'h1300_5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
